// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared sizing helpers and legality checks for the delta-sigma decimator
package dsm_pkg;

    localparam int ORDER_MIN     = 1;
    localparam int ORDER_MAX     = 4;
    localparam int RATE_LOG2_MIN = 1;
    localparam int RATE_LOG2_MAX = 8;

    // One guard bit above N*log2(R) lets a full-scale stream (R^N) be told apart from wrap.
    function automatic int cic_width(input int order, input int rate_log2);
        return order * rate_log2 + 1;
    endfunction

    function automatic int cic_shift(input int order, input int rate_log2, input int out_w);
        return order * rate_log2 - out_w;
    endfunction

    function automatic int sat_code(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    function automatic bit params_legal(input int order, input int rate_log2, input int out_w);
        return (order >= ORDER_MIN) && (order <= ORDER_MAX) &&
               (rate_log2 >= RATE_LOG2_MIN) && (rate_log2 <= RATE_LOG2_MAX) &&
               (out_w >= 1) && (order * rate_log2 >= out_w);
    endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// rtl/dsm_cic_comb.sv - CIC comb chain with differential delay 1, scaling and full-scale saturation
module dsm_cic_comb
    import dsm_pkg::*;
#(
    parameter int ORDER     = 3,
    parameter int RATE_LOG2 = 5,
    parameter int OUT_W     = 8,
    parameter int W         = cic_width(ORDER, RATE_LOG2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     din,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int                SHIFT = cic_shift(ORDER, RATE_LOG2, OUT_W);
    localparam logic [OUT_W-1:0]  SAT   = OUT_W'(sat_code(OUT_W));

    logic [W-1:0]     dly      [ORDER];
    logic [W-1:0]     stage_in [ORDER];
    logic [W-1:0]     cn;
    logic [OUT_W-1:0] scaled;

    always_comb begin
        cn = din;
        for (int k = 0; k < ORDER; k++) begin
            stage_in[k] = cn;
            cn          = cn - dly[k];
        end
    end

    assign scaled = OUT_W'(cn >> SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                dly[k] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= en;
            if (en) begin
                for (int k = 0; k < ORDER; k++) begin
                    dly[k] <= stage_in[k];
                end
                // MSB set means the comb result reached R^N: clamp rather than wrap to zero.
                out_data <= cn[W-1] ? SAT : scaled;
            end
        end
    end

endmodule

// File: rtl/dsm_decim.sv
// rtl/dsm_decim.sv - decimating CIC demodulator for a first-order delta-sigma 1-bit stream
module dsm_decim
    import dsm_pkg::*;
#(
    parameter int ORDER     = 3,
    parameter int RATE_LOG2 = 5,
    parameter int OUT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int W = cic_width(ORDER, RATE_LOG2);

    if (!params_legal(ORDER, RATE_LOG2, OUT_W)) begin : g_bad_params
        $error("dsm_decim: illegal ORDER/RATE_LOG2/OUT_W combination");
    end

    logic [W-1:0]         integ [ORDER];
    logic [RATE_LOG2-1:0] sample_cnt;
    logic                 tick;

    assign tick = in_valid && (&sample_cnt);

    // Integrators wrap freely; the comb differences undo the wrap exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
            sample_cnt <= '0;
        end else if (in_valid) begin
            integ[0] <= integ[0] + W'(in_bit);
            for (int k = 1; k < ORDER; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    dsm_cic_comb #(
        .ORDER     (ORDER),
        .RATE_LOG2 (RATE_LOG2),
        .OUT_W     (OUT_W),
        .W         (W)
    ) u_comb (
        .clk       (clk),
        .reset     (reset),
        .en        (tick),
        .din       (integ[ORDER-1]),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_dsm_decim.sv
// tb/tb_dsm_decim.sv - self-checking bench for dsm_decim against a closed-form CIC model
module tb_dsm_decim;

    localparam int ORDER     = 3;
    localparam int RATE_LOG2 = 5;
    localparam int OUT_W     = 8;
    localparam int R         = 1 << RATE_LOG2;
    localparam int W         = ORDER * RATE_LOG2 + 1;
    localparam int SHIFT     = ORDER * RATE_LOG2 - OUT_W;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_bit   = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;

    dsm_decim #(
        .ORDER     (ORDER),
        .RATE_LOG2 (RATE_LOG2),
        .OUT_W     (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    bit               chk_en   = 1'b0;
    bit               hist[$];
    longint           c0s[$];
    int               nacc     = 0;
    logic             m_valid  = 1'b0;
    logic [OUT_W-1:0] m_data   = '0;
    logic [OUT_W-1:0] got[$];
    logic [7:0]       dsm_acc  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint binom(input longint a, input int k);
        longint r;
        r = 1;
        for (int j = 0; j < k; j++) r = r * (a - j) / (j + 1);
        return r;
    endfunction

    // Last integrator after n accepted bits: each bit x_i weighted by C(n-1-i, N-1).
    function automatic longint integ_out(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) if (hist[i]) s += binom(longint'(n - 1 - i), ORDER - 1);
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] decode(input longint cn);
        longint m;
        m = cn & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W - 1))) return '1;
        return OUT_W'(m >> SHIFT);
    endfunction

    initial forever begin
        longint cn;
        int     idx;
        @(posedge clk);
        m_valid = 1'b0;
        if (reset) begin
            hist.delete();
            c0s.delete();
            nacc   = 0;
            m_data = '0;
        end else if (in_valid) begin
            hist.push_back(in_bit);
            nacc++;
            if (nacc % R == 0) begin
                c0s.push_back(integ_out(nacc - 1));
                cn = 0;
                for (int j = 0; j <= ORDER; j++) begin
                    idx = c0s.size() - 1 - j;
                    if (idx >= 0) cn += ((j % 2) ? -1 : 1) * binom(ORDER, j) * c0s[idx];
                end
                m_data  = decode(cn);
                m_valid = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("out_data", 32'(out_data), 32'(m_data));
            if (out_valid) got.push_back(out_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
    endtask

    task automatic dsm_run(input logic [7:0] d, input int n);
        logic [8:0] s;
        for (int i = 0; i < n; i++) begin
            s       = {1'b0, dsm_acc} + {1'b0, d};
            dsm_acc = s[7:0];
            drive(1'b1, s[8]);
        end
    endtask

    initial begin
        int  n;
        bit  in_range;
        logic b;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_valid", {31'd0, out_valid}, 0);
        check("reset_data", 32'(out_data), 0);

        for (int i = 0; i < R - 1; i++) drive(1'b1, 1'b0);
        check("no_early_strobe", {31'd0, out_valid}, 0);
        drive(1'b1, 1'b0);
        check("first_strobe_cycle", {31'd0, out_valid}, 1);
        for (int i = 0; i < 5 * R; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("zeros_count", got.size(), 6);
        foreach (got[i]) check("zeros_data", 32'(got[i]), 0);

        apply_reset();
        for (int i = 0; i < 8 * R; i++) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        check("ones_count", got.size(), 8);
        if (got.size() == 8) begin
            check("ones_first", 32'(got[0]), 35);
            check("ones_second", 32'(got[1]), 204);
            for (int i = 4; i < 8; i++) check("ones_saturated", 32'(got[i]), 8'hFF);
        end

        apply_reset();
        for (int i = 0; i < 12 * R; i++) drive(1'b1, (i % 2) == 0);
        drive(1'b0, 1'b0);
        check("alt_count", got.size(), 12);
        if (got.size() == 12) for (int i = 4; i < 12; i++) check("alt_half", 32'(got[i]), 8'h80);

        apply_reset();
        for (int i = 0; i < 10 * R; i++) drive(1'b1, (i % 4) == 0);
        drive(1'b0, 1'b0);
        check("quarter_count", got.size(), 10);
        if (got.size() == 10) check("quarter_value", 32'(got[9]), 8'h40);

        apply_reset();
        dsm_acc = 8'h00;
        dsm_run(8'hC0, 10 * R);
        dsm_run(8'h25, 10 * R);
        drive(1'b0, 1'b0);
        check("dsm_count", got.size(), 20);
        if (got.size() == 20) begin
            for (int i = 4; i < 10; i++) check("dsm_c0", 32'(got[i]), 8'hC0);
            for (int i = 14; i < 20; i++) begin
                in_range = (got[i] >= 8'h24) && (got[i] <= 8'h26);
                check("dsm_25_within_1lsb", {31'd0, in_range}, 1);
            end
        end

        apply_reset();
        b = 1'b1;
        for (int c = 0; c < 1500 && got.size() < 10; c++) begin
            if ($urandom_range(0, 1) != 0) begin
                drive(1'b1, b);
                b = ~b;
            end else begin
                drive(1'b0, 1'b0);
            end
        end
        drive(1'b0, 1'b0);
        check("gap_strobes", {31'd0, got.size() >= 10}, 1);
        if (got.size() >= 10) check("gap_alt_half", 32'(got[9]), 8'h80);

        apply_reset();
        for (int i = 0; i < 40 * R; i++) drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b0);

        apply_reset();
        for (int i = 0; i < 2 * R + 17; i++) drive(1'b1, 1'b1);
        check("pre_reset_data", 32'(out_data), 204);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_valid", {31'd0, out_valid}, 0);
        check("midreset_data", 32'(out_data), 0);
        n = 0;
        do begin
            drive(1'b1, 1'b0);
            n++;
        end while (!out_valid && n < 100);
        check("post_reset_strobe_after", n, R);
        drive(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
